oc8051_cxrom_arb: RTL and testbench
===================================

# oc8051_cxrom_arb

Two-port arbiter that shares the single combinational code ROM (`oc8051_cxrom`) between the oc8051 instruction-fetch path (CPU port) and the secure-boot measurement engine (MSR port). It picks one requester per cycle and drives the ROM address. It registers the 32-bit ROM word back to the winner with a one-cycle valid pulse. CPU has fixed priority, with a bounded-wait counter so that measurement reads cannot starve.

## Interface
- STARVE_LIMIT, default 4: consecutive denied MSR cycles before MSR is forced to win; range 0..255. 0 means MSR always wins when requesting.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- cpu_req  in  1  CPU read request; held until `cpu_ack`.
- cpu_addr  in  16  CPU ROM address; stable while `cpu_req` is high and not acked.
- cpu_ack  out  1  combinational grant to CPU this cycle.
- cpu_data  out  32  registered ROM word for the last CPU grant.
- cpu_valid  out  1  one-cycle pulse qualifying `cpu_data`.
- msr_req, msr_addr, msr_ack, msr_data, msr_valid: same as the CPU set, for the measurement port.
- cxrom_addr  out  16  address to `oc8051_cxrom`.
- cxrom_data_out  in  32  combinational ROM word for `cxrom_addr`.

## Operation
- State:
  - `wait_cnt` (8 bit): MSR wait cycles.
  - `gnt_q` (2 bit one-hot: cpu/msr/none): owner of the registered data.
  - Data and valid registers for each port.
- Winner selection each cycle (combinational):
  - When `rst` is high, there is no winner.
  - When only one port requests, that port wins.
  - When both ports request, MSR wins if `wait_cnt >= STARVE_LIMIT`. Otherwise CPU wins.
  - When neither port requests, there is no winner.
- Address mux:
  - `cxrom_addr` = winner address.
  - With no winner, `cxrom_addr` = `cpu_addr` (keeps the ROM output quiet). During `rst`, `cxrom_addr` = 0.
- Grant outputs: `cpu_ack` / `msr_ack` equal the winner decode. At most one is high in any cycle.
- Data capture: on the edge ending the grant cycle, the winner's data register loads `cxrom_data_out` and its valid register is set to 1. The other valid register is cleared. The loser's data register holds its value.
- `wait_cnt` update, in priority order:
  - Cleared on `rst`, on any MSR grant, or when `msr_req` = 0.
  - Otherwise incremented while `msr_req` is high and CPU wins.
  - Saturates at 255.
- Throughput: one grant per cycle. A requester that keeps `req` high after an ack is eligible again on the very next cycle (back-to-back reads).
- Protocol violations (address changes while a request is pending) are not checked. The ROM simply returns the word for the current address at the grant cycle.

## Timing
- Reset values: `cpu_ack` = 0, `msr_ack` = 0, `cpu_valid` = 0, `msr_valid` = 0, `cpu_data` = 0, `msr_data` = 0, `cxrom_addr` = 0, `wait_cnt` = 0.
- Request to ack: 0 cycles when uncontended. The ack is combinational in the same cycle as `req`.
- Ack to valid: exactly 1 cycle. Ack at cycle N gives valid high in cycle N+1 only, unless re-granted at N+1.
- Data stays stable after the valid pulse until the next grant to the same port.
- Contended MSR with STARVE_LIMIT = L: if both ports request continuously from cycle 0, CPU wins cycles 0..L-1 and MSR wins cycle L. The counter then clears, so the pattern is L CPU grants followed by 1 MSR grant.
- `rst` asserted mid-transfer: the pending valid pulse is suppressed and the data registers are cleared on that edge. No ack is issued while `rst` is high.
- Requests dropped before an ack produce no valid pulse and no state change, other than `wait_cnt` clearing when `msr_req` drops.

## Test plan
- Reset: hold `rst` with both requests high → both acks 0 and all outputs 0. Release `rst` → `cpu_ack` = 1 in the first cycle.
- Single CPU read: `cpu_req` = 1, `cpu_addr` = 16'h0010 at cycle N → `cpu_ack` = 1 at N and `cxrom_addr` = 16'h0010. At N+1, `cpu_valid` = 1 and `cpu_data` = ROM[16'h0010]; `msr_valid` stays 0.
- Back-to-back CPU reads: addresses 0, 1, 2 on consecutive acked cycles → valid is high for 3 consecutive cycles, carrying ROM[0], ROM[1], ROM[2] in order.
- Starvation, STARVE_LIMIT = 4: both ports request continuously → grant sequence is C, C, C, C, M, C, C, C, C, M. The `msr_valid` pulses land at cycles 5 and 10.
- STARVE_LIMIT = 0: both ports request → MSR wins every cycle and `cpu_ack` is never asserted.
- Reset mid-transfer: CPU acked at cycle N with `rst` = 1 at N+1 → `cpu_valid` = 0 and `cpu_data` = 0 after the edge. MSR with `wait_cnt` = 3 at the time of `rst` is back to 0 afterward.

Source files
------------

// File: rtl/oc8051_cxrom_arb_if.sv
// Bundle of the two requester ports and the shared code ROM connection.
// The arbiter uses the slave view. The requesters and the ROM use the master view.
interface oc8051_cxrom_arb_if;
  // CPU instruction-fetch port
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ack;
  logic [31:0] cpu_data;
  logic        cpu_valid;
  // Measurement-engine port
  logic        msr_req;
  logic [15:0] msr_addr;
  logic        msr_ack;
  logic [31:0] msr_data;
  logic        msr_valid;
  // Combinational code ROM
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_out;

  modport slave (
    input  cpu_req, cpu_addr, msr_req, msr_addr, cxrom_data_out,
    output cpu_ack, cpu_data, cpu_valid, msr_ack, msr_data, msr_valid, cxrom_addr
  );

  modport master (
    output cpu_req, cpu_addr, msr_req, msr_addr, cxrom_data_out,
    input  cpu_ack, cpu_data, cpu_valid, msr_ack, msr_data, msr_valid, cxrom_addr
  );
endinterface

// File: rtl/oc8051_cxrom_arb.sv
// Shares the combinational code ROM between the CPU fetch path and the
// measurement engine. CPU has fixed priority. A saturating wait counter
// forces an MSR grant after STARVE_LIMIT consecutive denied cycles.
// The ROM word is registered back to the winner with a one-cycle valid pulse.
module oc8051_cxrom_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  oc8051_cxrom_arb_if.slave  bus
);

  localparam int          NPORT = 2;          // index 0 = CPU, 1 = MSR
  localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]       r_wait_cnt;
  logic [NPORT-1:0] r_gnt_q;                  // one-hot owner of the registered data
  logic [NPORT-1:0] w_req;
  logic [NPORT-1:0] w_win;
  logic             w_starved;

  // Winner selection: CPU first unless MSR has waited long enough
  always_comb begin
    w_req     = {bus.msr_req, bus.cpu_req};
    w_starved = (r_wait_cnt >= LIMIT);
    w_win     = '0;
    if (!rst) begin
      if (w_req == 2'b11) begin
        w_win = w_starved ? 2'b10 : 2'b01;
      end else begin
        w_win = w_req;
      end
    end
  end

  // ROM address mux and grant decode; idle cycles park on the CPU address
  always_comb begin
    bus.cpu_ack = w_win[0];
    bus.msr_ack = w_win[1];
    if (rst) begin
      bus.cxrom_addr = '0;
    end else if (w_win[1]) begin
      bus.cxrom_addr = bus.msr_addr;
    end else begin
      bus.cxrom_addr = bus.cpu_addr;
    end
  end

  // MSR wait counter: clears when MSR is served or stops asking, else counts CPU wins
  always_ff @(posedge clk) begin
    if (rst || w_win[1] || !bus.msr_req) begin
      r_wait_cnt <= '0;
    end else if (w_win[0] && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Grant owner register; doubles as the per-port valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_q <= '0;
    end else begin
      r_gnt_q <= w_win;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_data
      logic [31:0] r_data;
      // Capture the ROM word for this port on the edge that ends its grant
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_win[gi]) begin
          r_data <= bus.cxrom_data_out;
        end
      end
    end
  endgenerate

  // Registered results back to the requesters
  always_comb begin
    bus.cpu_data  = g_data[0].r_data;
    bus.msr_data  = g_data[1].r_data;
    bus.cpu_valid = r_gnt_q[0];
    bus.msr_valid = r_gnt_q[1];
  end

endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Self-checking bench for oc8051_cxrom_arb. A behavioural model derived from
// the arbitration rules predicts acks, ROM address and registered results.
// A second instance with STARVE_LIMIT = 0 covers the MSR-always-wins case.
module tb_oc8051_cxrom_arb;

  localparam int L = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  oc8051_cxrom_arb_if b4 ();
  oc8051_cxrom_arb_if b0 ();

  oc8051_cxrom_arb #(.STARVE_LIMIT(L)) dut  (.clk(clk), .rst(rst), .bus(b4));
  oc8051_cxrom_arb #(.STARVE_LIMIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  // Stand-in code ROM: a fixed scramble of the address
  function automatic logic [31:0] rom(input logic [15:0] a);
    return {a ^ 16'hC35A, a * 16'd37 + 16'h0101};
  endfunction

  assign b4.cxrom_data_out = rom(b4.cxrom_addr);
  assign b0.cxrom_data_out = rom(b0.cxrom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  int          m_denied;
  bit          m_cval, m_mval;
  logic [31:0] m_cdata, m_mdata;

  // Per-cycle observation {cpu_ack, msr_ack, cxrom_addr, cpu_valid, msr_valid, cpu_data, msr_data}
  logic [83:0] exp_vec, obs_vec;
  logic [2:0]  obs0;            // STARVE_LIMIT=0 instance: {cpu_ack, msr_ack, msr_valid}

  // Drive one cycle of inputs, sample mid-cycle, then advance the model across the edge
  task automatic apply(input bit r, input bit cr, input logic [15:0] ca,
                       input bit mr, input logic [15:0] ma);
    int win;
    rst = r;
    b4.cpu_req = cr; b4.cpu_addr = ca; b4.msr_req = mr; b4.msr_addr = ma;
    b0.cpu_req = cr; b0.cpu_addr = ca; b0.msr_req = mr; b0.msr_addr = ma;
    @(negedge clk);
    if (r)              win = 0;
    else if (cr && mr)  win = (m_denied >= L) ? 2 : 1;
    else if (cr)        win = 1;
    else if (mr)        win = 2;
    else                win = 0;
    exp_vec = {win == 1, win == 2, r ? 16'h0000 : ((win == 2) ? ma : ca),
               m_cval, m_mval, m_cdata, m_mdata};
    obs_vec = {b4.cpu_ack, b4.msr_ack, b4.cxrom_addr, b4.cpu_valid, b4.msr_valid,
               b4.cpu_data, b4.msr_data};
    obs0    = {b0.cpu_ack, b0.msr_ack, b0.msr_valid};
    @(posedge clk);
    if (r) begin
      m_cval = 0; m_mval = 0; m_cdata = '0; m_mdata = '0; m_denied = 0;
    end else begin
      m_cval = (win == 1);
      m_mval = (win == 2);
      if (win == 1) m_cdata = rom(ca);
      if (win == 2) m_mdata = rom(ma);
      if (win == 2 || !mr) m_denied = 0;
      else if (m_denied < 255) m_denied = m_denied + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 16'h1234, 1, 16'h4321);
      n_vec++;
      if (obs_vec !== 84'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d got=%h want=0", i, obs_vec);
      end
    end
    apply(0, 1, 16'h1234, 1, 16'h4321);
    n_vec++;
    if (obs_vec[83:82] !== 2'b10 || obs_vec[81:66] !== 16'h1234) begin
      n_fail++;
      $display("FAIL reset_release acks/addr got=%b/%h want=10/1234", obs_vec[83:82], obs_vec[81:66]);
    end
  endtask

  task automatic test_single();
    apply(0, 1, 16'h0010, 0, 16'hBEEF);
    n_vec++;
    if (obs_vec[83:82] !== 2'b10 || obs_vec[81:66] !== 16'h0010) begin
      n_fail++;
      $display("FAIL single_ack acks/addr got=%b/%h want=10/0010", obs_vec[83:82], obs_vec[81:66]);
    end
    apply(0, 0, 16'h0010, 0, 16'hBEEF);
    n_vec++;
    if (obs_vec[65:64] !== 2'b10 || obs_vec[63:32] !== rom(16'h0010)) begin
      n_fail++;
      $display("FAIL single_data valid/data got=%b/%h want=10/%h", obs_vec[65:64], obs_vec[63:32], rom(16'h0010));
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL single_model got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      apply(0, i < 3, 16'(i), 0, 16'h0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL b2b_model cyc%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_vec[65] !== 1'b1 || obs_vec[63:32] !== rom(16'(i - 1))) begin
          n_fail++;
          $display("FAIL b2b_data cyc%0d got=%b/%h want=1/%h", i, obs_vec[65], obs_vec[63:32], rom(16'(i - 1)));
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    apply(0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i <= 10; i++) begin
      apply(0, 1, 16'h0100 + 16'(i), 1, 16'h0200 + 16'(i));
      want = ((i % (L + 1)) == L) ? 2'b01 : 2'b10;
      n_vec++;
      if (obs_vec[83:82] !== want || obs_vec[64] !== (i == 5 || i == 10)) begin
        n_fail++;
        $display("FAIL starve cyc%0d acks/mval got=%b/%b want=%b/%b", i, obs_vec[83:82], obs_vec[64], want, (i == 5 || i == 10));
      end
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL starve_model cyc%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_limit0();
    apply(0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 16'h0300, 1, 16'h0400 + 16'(i));
      n_vec++;
      if (obs0 !== ((i == 0) ? 3'b010 : 3'b011)) begin
        n_fail++;
        $display("FAIL limit0 cyc%0d {cack,mack,mval} got=%b want=%b", i, obs0, (i == 0) ? 3'b010 : 3'b011);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 3; i++) apply(0, 1, 16'h0500, 1, 16'h0600);
    apply(1, 1, 16'h0500, 1, 16'h0600);
    n_vec++;
    if (obs_vec[83:82] !== 2'b00 || obs_vec[65] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_during acks/cval got=%b/%b want=00/1", obs_vec[83:82], obs_vec[65]);
    end
    for (int k = 0; k <= L; k++) begin
      apply(0, 1, 16'h0500, 1, 16'h0600);
      if (k == 0) begin
        n_vec++;
        if (obs_vec[65:64] !== 2'b00 || obs_vec[63:0] !== 64'h0) begin
          n_fail++;
          $display("FAIL rstmid_cleared valid/data got=%b/%h want=00/0", obs_vec[65:64], obs_vec[63:0]);
        end
      end
      n_vec++;
      if (obs_vec[83:82] !== ((k == L) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rstmid_wait_cleared k%0d acks got=%b want=%b", k, obs_vec[83:82], (k == L) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_random();
    bit r, cr, mr;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      cr = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      apply(r, cr, 16'($urandom), mr, 16'($urandom));
      n_vec++;
      if (obs_vec !== exp_vec || obs_vec[83:82] == 2'b11) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    m_denied = 0; m_cval = 0; m_mval = 0; m_cdata = '0; m_mdata = '0;
    rst = 1'b1;
    b4.cpu_req = 0; b4.cpu_addr = '0; b4.msr_req = 0; b4.msr_addr = '0;
    b0.cpu_req = 0; b0.cpu_addr = '0; b0.msr_req = 0; b0.msr_addr = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_starvation();
    test_limit0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
